// File: rtl/dcache_pkg.sv
// Shared types for the dcache miss-status holding table: bus commands,
// entry states, and the per-entry record.
`ifndef DCACHE_BLOCK_SIZE
`define DCACHE_BLOCK_SIZE 64
`endif

package dcache_pkg;

  localparam int DCACHE_BLOCK_BITS = `DCACHE_BLOCK_SIZE;
  localparam int MSHR_AGE_W        = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    MSHR_FREE  = 2'h0,
    MSHR_ISSUE = 2'h1,
    MSHR_WAIT  = 2'h2
  } MSHR_STATE;

  typedef struct packed {
    MSHR_STATE                    state;
    BUS_COMMAND                   command;
    logic [63:0]                  addr;
    logic [DCACHE_BLOCK_BITS-1:0] data;
    logic [3:0]                   mem_tag;
    logic [MSHR_AGE_W-1:0]        age;
  } mshr_entry_t;

  // Block address: the byte offset within an 8-byte block is dropped.
  function automatic logic [63:0] block_addr(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/dcache_mshr_pick.sv
// Selects one candidate entry: the one with the largest age value, ties
// going to the lowest index. With all ages equal this is a plain
// lowest-index priority pick.
module dcache_mshr_pick #(
  parameter int N     = 4,
  parameter int AGE_W = 4
) (
  input  logic [N-1:0]         cand,
  input  logic [N*AGE_W-1:0]   ages,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  logic [AGE_W-1:0] best_age;

  // Scan upward; only a strictly older candidate displaces the current pick.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && (!found || (ages[i*AGE_W +: AGE_W] > best_age))) begin
        found    = 1'b1;
        idx      = IDX_W'(i);
        best_age = ages[i*AGE_W +: AGE_W];
      end
    end
  end

endmodule

// File: rtl/dcache_mshr.sv
// Miss-status holding table between the dcache controller and data memory.
// Holds block fetches and dirty-victim writebacks, issues the oldest pending
// one per cycle, retries rejected issues and routes returning load data
// back to the controller as a one-cycle fill.
module dcache_mshr
  import dcache_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int BLOCK_BITS  = DCACHE_BLOCK_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  BUS_COMMAND            req_command,
  input  logic [63:0]           req_addr,
  input  logic [BLOCK_BITS-1:0] req_data,
  output logic                  req_ready,
  output logic                  req_dup,
  output BUS_COMMAND            proc2Dmem_command,
  output logic [63:0]           proc2Dmem_addr,
  output logic [BLOCK_BITS-1:0] proc2Dmem_data,
  input  logic [3:0]            Dmem2proc_response,
  input  logic [3:0]            Dmem2proc_tag,
  input  logic [BLOCK_BITS-1:0] Dmem2proc_data,
  output logic                  fill_valid,
  output logic [63:0]           fill_addr,
  output logic [BLOCK_BITS-1:0] fill_data,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [MSHR_AGE_W-1:0] AGE_MAX = '1;

  mshr_entry_t tbl [NUM_ENTRIES];

  logic [63:0]                       req_blk;
  logic [NUM_ENTRIES-1:0]            free_vec, issue_vec, ld_hit, st_hit;
  logic [NUM_ENTRIES*MSHR_AGE_W-1:0] issue_ages, zero_ages;
  logic                              alloc_found, iss_found, comp_found;
  logic [IDX_W-1:0]                  alloc_idx, iss_idx, comp_idx;
  logic                              dup, conflict, do_alloc, iss_accept;

  logic                  fill_vld_p1;
  logic [63:0]           fill_addr_p1;
  logic [BLOCK_BITS-1:0] fill_data_p1;

  assign req_blk   = block_addr(req_addr);
  assign zero_ages = '0;

  // Per-entry decode of start-of-cycle state: free/issue masks, address
  // hits against the offered request, and the completion tag match.
  always_comb begin
    free_vec   = '0;
    issue_vec  = '0;
    ld_hit     = '0;
    st_hit     = '0;
    issue_ages = '0;
    comp_found = 1'b0;
    comp_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i]  = (tbl[i].state == MSHR_FREE);
      issue_vec[i] = (tbl[i].state == MSHR_ISSUE);
      ld_hit[i]    = !free_vec[i] && (tbl[i].command == BUS_LOAD) && (tbl[i].addr == req_blk);
      st_hit[i]    = !free_vec[i] && (tbl[i].command == BUS_STORE) && (tbl[i].addr == req_blk);
      issue_ages[i*MSHR_AGE_W +: MSHR_AGE_W] = tbl[i].age;
      // An entry issuing this cycle is still ISSUE, so a response tag equal
      // to the completion tag can only match the older WAIT entry.
      if ((Dmem2proc_tag != 4'd0) && (tbl[i].state == MSHR_WAIT) &&
          (tbl[i].mem_tag == Dmem2proc_tag)) begin
        comp_found = 1'b1;
        comp_idx   = IDX_W'(i);
      end
    end
  end

  dcache_mshr_pick #(.N(NUM_ENTRIES), .AGE_W(MSHR_AGE_W)) u_alloc_pick (
    .cand  (free_vec),
    .ages  (zero_ages),
    .found (alloc_found),
    .idx   (alloc_idx)
  );

  dcache_mshr_pick #(.N(NUM_ENTRIES), .AGE_W(MSHR_AGE_W)) u_issue_pick (
    .cand  (issue_vec),
    .ages  (issue_ages),
    .found (iss_found),
    .idx   (iss_idx)
  );

  // Request handshake: duplicate loads merge even when full; any ordering
  // hazard against an outstanding store (or a store over a pending load) stalls.
  always_comb begin
    dup       = req_valid && (req_command == BUS_LOAD) && (|ld_hit);
    conflict  = (|st_hit) || ((req_command == BUS_STORE) && (|ld_hit));
    req_ready = dup || ((req_command != BUS_NONE) && !conflict && alloc_found);
    req_dup   = dup;
    do_alloc  = req_valid && req_ready && !dup;
  end

  // Bus drive comes purely from table state, so a fresh allocation waits a cycle.
  always_comb begin
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    iss_accept        = 1'b0;
    if (iss_found) begin
      proc2Dmem_command = tbl[iss_idx].command;
      proc2Dmem_addr    = tbl[iss_idx].addr;
      proc2Dmem_data    = tbl[iss_idx].data;
      iss_accept        = (Dmem2proc_response != 4'd0);
    end
  end

  assign busy = ~(&free_vec);

  // Table update: allocation, issue acceptance and completion touch disjoint
  // entries (FREE, ISSUE, WAIT respectively) so all apply in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (do_alloc && (alloc_idx == IDX_W'(i))) begin
          tbl[i].state   <= MSHR_ISSUE;
          tbl[i].command <= req_command;
          tbl[i].addr    <= req_blk;
          tbl[i].data    <= (req_command == BUS_STORE) ? req_data : '0;
          tbl[i].mem_tag <= 4'd0;
          tbl[i].age     <= '0;
        end else begin
          // Ages saturate; a tie between saturated entries resolves by index.
          if (do_alloc && !free_vec[i] && (tbl[i].age != AGE_MAX))
            tbl[i].age <= tbl[i].age + MSHR_AGE_W'(1);
          if (iss_accept && (iss_idx == IDX_W'(i))) begin
            if (tbl[i].command == BUS_LOAD) begin
              tbl[i].state   <= MSHR_WAIT;
              tbl[i].mem_tag <= Dmem2proc_response;
            end else begin
              tbl[i].state <= MSHR_FREE;
            end
          end
          if (comp_found && (comp_idx == IDX_W'(i)))
            tbl[i].state <= MSHR_FREE;
        end
      end
    end
  end

  // Stage p1: completion data registered into a one-cycle fill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_vld_p1  <= 1'b0;
      fill_addr_p1 <= '0;
      fill_data_p1 <= '0;
    end else begin
      fill_vld_p1 <= comp_found;
      if (comp_found) begin
        fill_addr_p1 <= tbl[comp_idx].addr;
        fill_data_p1 <= Dmem2proc_data;
      end
    end
  end

  assign fill_valid = fill_vld_p1;
  assign fill_addr  = fill_addr_p1;
  assign fill_data  = fill_data_p1;

endmodule

// File: tb/tb_dcache_mshr.sv
// Directed bench for dcache_mshr: a table of one-cycle vectors covering
// fetch/fill, store retry, full/dup, ordering stalls and tag handling,
// followed by a hand-written mid-operation reset sequence.
module tb_dcache_mshr;
  import dcache_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  BUS_COMMAND       req_command;
  logic [63:0]      req_addr;
  logic [63:0]      req_data;
  logic             req_ready;
  logic             req_dup;
  BUS_COMMAND       proc2Dmem_command;
  logic [63:0]      proc2Dmem_addr;
  logic [63:0]      proc2Dmem_data;
  logic [3:0]       Dmem2proc_response;
  logic [3:0]       Dmem2proc_tag;
  logic [63:0]      Dmem2proc_data;
  logic             fill_valid;
  logic [63:0]      fill_addr;
  logic [63:0]      fill_data;
  logic             busy;

  always #5 clock = ~clock;

  dcache_mshr #(.NUM_ENTRIES(4), .BLOCK_BITS(64)) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_command        (req_command),
    .req_addr           (req_addr),
    .req_data           (req_data),
    .req_ready          (req_ready),
    .req_dup            (req_dup),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_tag      (Dmem2proc_tag),
    .Dmem2proc_data     (Dmem2proc_data),
    .fill_valid         (fill_valid),
    .fill_addr          (fill_addr),
    .fill_data          (fill_data),
    .busy               (busy)
  );

  typedef struct {
    logic        rv;
    BUS_COMMAND  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  rsp;
    logic [3:0]  tag;
    logic [63:0] ddata;
    logic        e_ready;
    logic        e_dup;
    BUS_COMMAND  e_cmd;
    logic [63:0] e_paddr;
    logic [63:0] e_pdata;
    logic        e_fv;
    logic [63:0] e_faddr;
    logic [63:0] e_fdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic rv, input BUS_COMMAND c, input logic [63:0] a,
                     input logic [63:0] d, input logic [3:0] rsp, input logic [3:0] tg,
                     input logic [63:0] dd, input logic er, input logic edp,
                     input BUS_COMMAND ec, input logic [63:0] epa, input logic [63:0] epd,
                     input logic efv, input logic [63:0] efa, input logic [63:0] efd,
                     input logic eb);
    vec_t v;
    v.rv = rv; v.cmd = c; v.addr = a; v.data = d; v.rsp = rsp; v.tag = tg; v.ddata = dd;
    v.e_ready = er; v.e_dup = edp; v.e_cmd = ec; v.e_paddr = epa; v.e_pdata = epd;
    v.e_fv = efv; v.e_faddr = efa; v.e_fdata = efd; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    req_valid          = 1'b0;
    req_command        = BUS_NONE;
    req_addr           = '0;
    req_data           = '0;
    Dmem2proc_response = 4'd0;
    Dmem2proc_tag      = 4'd0;
    Dmem2proc_data     = '0;
  endtask

  task automatic check_reset_outputs(input int row);
    chk("rst_busy", row, {63'd0, busy}, 64'd0);
    chk("rst_cmd", row, {62'd0, proc2Dmem_command}, 64'd0);
    chk("rst_paddr", row, proc2Dmem_addr, 64'd0);
    chk("rst_pdata", row, proc2Dmem_data, 64'd0);
    chk("rst_fill_valid", row, {63'd0, fill_valid}, 64'd0);
    chk("rst_fill_addr", row, fill_addr, 64'd0);
    chk("rst_fill_data", row, fill_data, 64'd0);
  endtask

  initial begin
    int tags[3];
    vec_t v;
    tags = '{6, 8, 0};

    // rv cmd addr data rsp tag ddata | ready dup cmd paddr pdata | fv faddr fdata | busy
    // Load fetch, accepted with tag 3, filled two cycles later.
    add(1, BUS_LOAD,  64'h1000, 0, 0, 0, 0,        1, 0, BUS_NONE,  0,       0,      0, 0,       0,      0);
    add(0, BUS_NONE,  0,        0, 3, 0, 0,        0, 0, BUS_LOAD,  64'h1000, 0,     0, 0,       0,      1);
    add(0, BUS_NONE,  0,        0, 0, 0, 0,        0, 0, BUS_NONE,  0,       0,      0, 0,       0,      1);
    add(0, BUS_NONE,  0,        0, 0, 3, 64'hDEAD, 0, 0, BUS_NONE,  0,       0,      0, 0,       0,      1);
    add(0, BUS_NONE,  0,        0, 0, 0, 0,        0, 0, BUS_NONE,  0,       0,      1, 64'h1000, 64'hDEAD, 0);
    add(0, BUS_NONE,  0,        0, 0, 0, 0,        0, 0, BUS_NONE,  0,       0,      0, 0,       0,      0);
    // Writeback rejected twice, accepted on the third issue.
    add(1, BUS_STORE, 64'h2000, 64'hBEEF, 0, 0, 0, 1, 0, BUS_NONE,  0,       0,      0, 0,       0,      0);
    add(0, BUS_NONE,  0,        0, 0, 0, 0,        0, 0, BUS_STORE, 64'h2000, 64'hBEEF, 0, 0,    0,      1);
    add(0, BUS_NONE,  0,        0, 0, 0, 0,        0, 0, BUS_STORE, 64'h2000, 64'hBEEF, 0, 0,    0,      1);
    add(0, BUS_NONE,  0,        0, 5, 0, 0,        0, 0, BUS_STORE, 64'h2000, 64'hBEEF, 0, 0,    0,      1);
    add(0, BUS_NONE,  0,        0, 0, 0, 0,        0, 0, BUS_NONE,  0,       0,      0, 0,       0,      0);
    // Fill all four entries; full stalls new blocks, duplicates still merge.
    add(1, BUS_LOAD,  64'h1000, 0, 0, 0, 0,        1, 0, BUS_NONE,  0,       0,      0, 0,       0,      0);
    add(1, BUS_LOAD,  64'h1100, 0, 1, 0, 0,        1, 0, BUS_LOAD,  64'h1000, 0,     0, 0,       0,      1);
    add(1, BUS_LOAD,  64'h1200, 0, 2, 0, 0,        1, 0, BUS_LOAD,  64'h1100, 0,     0, 0,       0,      1);
    add(1, BUS_LOAD,  64'h1300, 0, 0, 0, 0,        1, 0, BUS_LOAD,  64'h1200, 0,     0, 0,       0,      1);
    add(1, BUS_LOAD,  64'h1400, 0, 0, 0, 0,        0, 0, BUS_LOAD,  64'h1200, 0,     0, 0,       0,      1);
    add(1, BUS_LOAD,  64'h1000, 0, 4, 0, 0,        1, 1, BUS_LOAD,  64'h1200, 0,     0, 0,       0,      1);
    add(1, BUS_LOAD,  64'h1200, 0, 0, 0, 0,        1, 1, BUS_LOAD,  64'h1300, 0,     0, 0,       0,      1);
    add(1, BUS_LOAD,  64'h1300, 0, 6, 0, 0,        1, 1, BUS_LOAD,  64'h1300, 0,     0, 0,       0,      1);
    // Unknown tag dropped; a freed entry is not reusable in the same cycle.
    add(0, BUS_NONE,  0,        0, 0, 9, 64'h9999, 0, 0, BUS_NONE,  0,       0,      0, 0,       0,      1);
    add(1, BUS_LOAD,  64'h1400, 0, 0, 1, 64'hAAAA, 0, 0, BUS_NONE,  0,       0,      0, 0,       0,      1);
    // Store 0x3000 blocks a load of the same block until it is accepted.
    add(1, BUS_STORE, 64'h3000, 64'h3333, 0, 4, 64'hBBBB, 1, 0, BUS_NONE, 0,  0,      1, 64'h1000, 64'hAAAA, 1);
    add(1, BUS_LOAD,  64'h3000, 0, 0, 0, 0,        0, 0, BUS_STORE, 64'h3000, 64'h3333, 1, 64'h1200, 64'hBBBB, 1);
    add(1, BUS_LOAD,  64'h3000, 0, 7, 0, 0,        0, 0, BUS_STORE, 64'h3000, 64'h3333, 0, 0,   0,      1);
    add(1, BUS_LOAD,  64'h3000, 0, 0, 0, 0,        1, 0, BUS_NONE,  0,       0,      0, 0,       0,      1);
    // Store over a pending load stalls even with a free entry.
    add(1, BUS_STORE, 64'h1100, 64'h1, 0, 0, 0,    0, 0, BUS_LOAD,  64'h3000, 0,     0, 0,       0,      1);
    // Same-cycle response tag 2 and completion tag 2: completion hits the older entry.
    add(0, BUS_NONE,  0,        0, 2, 2, 64'h5555, 0, 0, BUS_LOAD,  64'h3000, 0,     0, 0,       0,      1);
    add(0, BUS_NONE,  0,        0, 0, 0, 0,        0, 0, BUS_NONE,  0,       0,      1, 64'h1100, 64'h5555, 1);
    add(0, BUS_NONE,  0,        0, 0, 2, 64'h6666, 0, 0, BUS_NONE,  0,       0,      0, 0,       0,      1);
    // Unaligned request address: offset bits are dropped.
    add(1, BUS_LOAD,  64'h5007, 0, 0, 0, 0,        1, 0, BUS_NONE,  0,       0,      1, 64'h3000, 64'h6666, 1);
    add(0, BUS_NONE,  0,        0, 8, 0, 0,        0, 0, BUS_LOAD,  64'h5000, 0,     0, 0,       0,      1);
    add(0, BUS_NONE,  0,        0, 0, 0, 0,        0, 0, BUS_NONE,  0,       0,      0, 0,       0,      1);

    idle_inputs();
    reset = 1'b0;
    #12;
    check_reset_outputs(-1);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clock);
      #1;
      req_valid          = v.rv;
      req_command        = v.cmd;
      req_addr           = v.addr;
      req_data           = v.data;
      Dmem2proc_response = v.rsp;
      Dmem2proc_tag      = v.tag;
      Dmem2proc_data     = v.ddata;
      @(negedge clock);
      chk("req_ready", i, {63'd0, req_ready}, {63'd0, v.e_ready});
      chk("req_dup", i, {63'd0, req_dup}, {63'd0, v.e_dup});
      chk("mem_cmd", i, {62'd0, proc2Dmem_command}, {62'd0, v.e_cmd});
      chk("mem_addr", i, proc2Dmem_addr, v.e_paddr);
      chk("mem_data", i, proc2Dmem_data, v.e_pdata);
      chk("fill_valid", i, {63'd0, fill_valid}, {63'd0, v.e_fv});
      if (v.e_fv) begin
        chk("fill_addr", i, fill_addr, v.e_faddr);
        chk("fill_data", i, fill_data, v.e_fdata);
      end
      chk("busy", i, {63'd0, busy}, {63'd0, v.e_busy});
    end

    // Two loads are waiting (tags 6 and 8); reset mid-cycle clears them.
    @(posedge clock);
    #1;
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs(100);
    @(negedge clock);
    reset = 1'b1;

    // Their tags come back after reset and must find nothing.
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      Dmem2proc_tag  = tags[k][3:0];
      Dmem2proc_data = 64'hF00D;
      @(negedge clock);
      chk("post_rst_fill_valid", 101 + k, {63'd0, fill_valid}, 64'd0);
      chk("post_rst_busy", 101 + k, {63'd0, busy}, 64'd0);
    end
    @(posedge clock);
    #1;
    idle_inputs();
    @(negedge clock);
    check_reset_outputs(104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
